terminal_controller: RTL and testbench

TERMINAL_CONTROLLER -- requirements
Module: terminal_controller

---
 rtl/term_pkg.sv | 21 ++
 rtl/terminal_controller.sv | 194 +++++++++++++++++++
 tb/tb_terminal_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/term_pkg.sv
// rtl/term_pkg.sv - shared constants and state type for the text terminal controller
// Purpose: screen geometry defaults, blank code, control codes, FSM state enum.
// Ports: none (package).
package term_pkg;

  localparam int         ROWS  = 40;
  localparam int         COLS  = 64;
  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;

  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    IDLE      = 2'd1,
    CLEAR_ROW = 2'd2
  } state_t;

endpackage

// File: rtl/terminal_controller.sv
// rtl/terminal_controller.sv - character stream to scrolling text RAM writer
// Purpose: consumes ASCII characters, maintains a cursor and a circular top row,
//          and issues single-port writes into a character RAM.
// Ports:
//   pixel_clk_in          clock, rst_in synchronous active-high reset
//   char_valid_in/char_in character input, accepted when char_ready_out=1
//   char_ready_out        high only in IDLE
//   mem_we_out/mem_addr_out/mem_data_out  character RAM write port, addr={phys_row,col}
//   cursor_row_out/cursor_col_out         logical cursor position
//   top_row_out           physical RAM row displayed as screen row 0
module terminal_controller
  import term_pkg::*;
#(
  parameter int         ROWS  = term_pkg::ROWS,
  parameter int         COLS  = term_pkg::COLS,
  parameter logic [7:0] BLANK = term_pkg::BLANK
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        char_valid_in,
  input  logic [7:0]  char_in,
  output logic        char_ready_out,
  output logic        mem_we_out,
  output logic [11:0] mem_addr_out,
  output logic [7:0]  mem_data_out,
  output logic [5:0]  cursor_row_out,
  output logic [5:0]  cursor_col_out,
  output logic [5:0]  top_row_out
);

  localparam int          COL_BITS = $clog2(COLS);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);
  localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
  localparam logic [11:0] ALL_LAST = 12'(ROWS * COLS - 1);
  localparam logic [11:0] ROW_LAST = 12'(COLS - 1);

  // Both operands are below ROWS, so one conditional subtract is a full modulo.
  function automatic logic [5:0] phys(input logic [5:0] top, input logic [5:0] row);
    logic [6:0] s;
    s = {1'b0, top} + {1'b0, row};
    if (s >= 7'(ROWS)) s = s - 7'(ROWS);
    return s[5:0];
  endfunction

  state_t      r_state, w_state_n;
  logic [11:0] r_cnt, w_cnt_n;
  logic [5:0]  r_row, w_row_n;
  logic [5:0]  r_col, w_col_n;
  logic [5:0]  r_top, w_top_n;
  logic        r_we, w_we_n;
  logic [11:0] r_addr, w_addr_n;
  logic [7:0]  r_data, w_data_n;
  logic        w_scroll;

  logic [5:0]  w_phys;
  logic [5:0]  w_bot;
  logic [5:0]  w_clr_row;
  logic [5:0]  w_clr_col;

  assign w_phys    = phys(r_top, r_row);
  assign w_bot     = phys(r_top, LAST_ROW);
  assign w_clr_row = 6'(r_cnt >> COL_BITS);
  assign w_clr_col = r_cnt[5:0] & LAST_COL;

  // Writes are registered, so every write appears one cycle after the state
  // cycle that produced it; gating with reset keeps the strobe quiet at once.
  assign char_ready_out = (r_state == IDLE) && !rst_in;
  assign mem_we_out     = r_we && !rst_in;
  assign mem_addr_out   = r_addr;
  assign mem_data_out   = r_data;
  assign cursor_row_out = r_row;
  assign cursor_col_out = r_col;
  assign top_row_out    = r_top;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state <= CLEAR_ALL;
      r_cnt   <= 12'd0;
      r_row   <= 6'd0;
      r_col   <= 6'd0;
      r_top   <= 6'd0;
      r_we    <= 1'b0;
      r_addr  <= 12'd0;
      r_data  <= 8'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_row   <= w_row_n;
      r_col   <= w_col_n;
      r_top   <= w_top_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_row_n   = r_row;
    w_col_n   = r_col;
    w_top_n   = r_top;
    w_we_n    = 1'b0;
    w_addr_n  = r_addr;
    w_data_n  = r_data;
    w_scroll  = 1'b0;

    case (r_state)
      CLEAR_ALL: begin
        w_we_n   = 1'b1;
        w_addr_n = {w_clr_row, w_clr_col};
        w_data_n = BLANK;
        if (r_cnt == ALL_LAST) begin
          w_state_n = IDLE;
          w_cnt_n   = 12'd0;
        end else begin
          w_cnt_n = r_cnt + 12'd1;
        end
      end

      CLEAR_ROW: begin
        w_we_n   = 1'b1;
        w_addr_n = {w_bot, r_cnt[5:0]};
        w_data_n = BLANK;
        if (r_cnt == ROW_LAST) begin
          w_state_n = IDLE;
          w_cnt_n   = 12'd0;
        end else begin
          w_cnt_n = r_cnt + 12'd1;
        end
      end

      IDLE: begin
        if (char_valid_in) begin
          if (char_in >= 8'h20 && char_in <= 8'h7E) begin
            w_we_n   = 1'b1;
            w_addr_n = {w_phys, r_col};
            w_data_n = char_in;
            if (r_col == LAST_COL) begin
              w_col_n = 6'd0;
              if (r_row != LAST_ROW) w_row_n = r_row + 6'd1;
              else                   w_scroll = 1'b1;
            end else begin
              w_col_n = r_col + 6'd1;
            end
          end else begin
            case (char_in)
              LF: begin
                if (r_row != LAST_ROW) w_row_n = r_row + 6'd1;
                else                   w_scroll = 1'b1;
              end
              CR: w_col_n = 6'd0;
              BS: begin
                if (r_col != 6'd0) begin
                  w_col_n  = r_col - 6'd1;
                  w_we_n   = 1'b1;
                  w_addr_n = {w_phys, r_col - 6'd1};
                  w_data_n = BLANK;
                end else if (r_row != 6'd0) begin
                  w_row_n  = r_row - 6'd1;
                  w_col_n  = LAST_COL;
                  w_we_n   = 1'b1;
                  w_addr_n = {phys(r_top, r_row - 6'd1), LAST_COL};
                  w_data_n = BLANK;
                end
              end
              FF: begin
                w_state_n = CLEAR_ALL;
                w_cnt_n   = 12'd0;
                w_row_n   = 6'd0;
                w_col_n   = 6'd0;
                w_top_n   = 6'd0;
              end
              default: ;
            endcase
          end

          // The cleared row is the old top row, which becomes the new bottom.
          if (w_scroll) begin
            w_top_n   = (r_top == LAST_ROW) ? 6'd0 : r_top + 6'd1;
            w_state_n = CLEAR_ROW;
            w_cnt_n   = 12'd0;
          end
        end
      end

      default: begin
        w_state_n = CLEAR_ALL;
        w_cnt_n   = 12'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_terminal_controller.sv
// tb/tb_terminal_controller.sv - directed table-driven bench for terminal_controller
module tb_terminal_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  ch;
  logic        ready;
  logic        we;
  logic [11:0] addr;
  logic [7:0]  data;
  logic [5:0]  crow, ccol, ctop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  terminal_controller dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .char_valid_in  (valid),
    .char_in        (ch),
    .char_ready_out (ready),
    .mem_we_out     (we),
    .mem_addr_out   (addr),
    .mem_data_out   (data),
    .cursor_row_out (crow),
    .cursor_col_out (ccol),
    .top_row_out    (ctop)
  );

  typedef struct {
    logic [7:0]  c;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  data;
    logic [5:0]  row;
    logic [5:0]  col;
    logic [5:0]  top;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one character at a negedge, return at the negedge after acceptance.
  task automatic send(input logic [7:0] c);
    int k = 0;
    while (!ready && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (!ready) chk("send_ready_timeout", 32'(ready), 32'd1);
    valid = 1'b1;
    ch    = c;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    ch    = 8'h00;
  endtask

  task automatic check_full_clear(input string name);
    int n = 0;
    int errs = 0;
    int k = 0;
    while (k < 3000) begin
      if (we) begin
        if (addr !== 12'(n) || data !== 8'h20) errs++;
        n++;
      end
      if (ready) break;
      @(negedge clk);
      k++;
    end
    chk({name, "_timeout"}, 32'(ready), 32'd1);
    chk({name, "_writes"}, 32'(n), 32'd2560);
    chk({name, "_seq_errs"}, 32'(errs), 32'd0);
    chk({name, "_cursor"}, {20'd0, crow, ccol}, 32'd0);
  endtask

  initial begin
    int lowcnt, wcnt, errs, k;

    tbl[0]  = '{8'h41, 1'b1, 12'h000, 8'h41, 6'd0, 6'd1,  6'd0};
    tbl[1]  = '{8'h42, 1'b1, 12'h001, 8'h42, 6'd0, 6'd2,  6'd0};
    tbl[2]  = '{8'h0D, 1'b0, 12'h000, 8'h00, 6'd0, 6'd0,  6'd0};
    tbl[3]  = '{8'h0A, 1'b0, 12'h000, 8'h00, 6'd1, 6'd0,  6'd0};
    tbl[4]  = '{8'h01, 1'b0, 12'h000, 8'h00, 6'd1, 6'd0,  6'd0};
    tbl[5]  = '{8'h08, 1'b1, 12'h03F, 8'h20, 6'd0, 6'd63, 6'd0};
    tbl[6]  = '{8'h43, 1'b1, 12'h03F, 8'h43, 6'd1, 6'd0,  6'd0};
    tbl[7]  = '{8'h08, 1'b1, 12'h03F, 8'h20, 6'd0, 6'd63, 6'd0};
    tbl[8]  = '{8'h0D, 1'b0, 12'h000, 8'h00, 6'd0, 6'd0,  6'd0};
    tbl[9]  = '{8'h08, 1'b0, 12'h000, 8'h00, 6'd0, 6'd0,  6'd0};
    tbl[10] = '{8'h7E, 1'b1, 12'h000, 8'h7E, 6'd0, 6'd1,  6'd0};
    tbl[11] = '{8'h7F, 1'b0, 12'h000, 8'h00, 6'd0, 6'd1,  6'd0};
    tbl[12] = '{8'h1F, 1'b0, 12'h000, 8'h00, 6'd0, 6'd1,  6'd0};
    tbl[13] = '{8'h20, 1'b1, 12'h001, 8'h20, 6'd0, 6'd2,  6'd0};
    tbl[14] = '{8'h08, 1'b1, 12'h001, 8'h20, 6'd0, 6'd1,  6'd0};
    tbl[15] = '{8'h0D, 1'b0, 12'h000, 8'h00, 6'd0, 6'd0,  6'd0};
    tbl[16] = '{8'h0A, 1'b0, 12'h000, 8'h00, 6'd1, 6'd0,  6'd0};
    tbl[17] = '{8'h0A, 1'b0, 12'h000, 8'h00, 6'd2, 6'd0,  6'd0};
    tbl[18] = '{8'h0A, 1'b0, 12'h000, 8'h00, 6'd3, 6'd0,  6'd0};
    tbl[19] = '{8'h08, 1'b1, 12'h0BF, 8'h20, 6'd2, 6'd63, 6'd0};
    tbl[20] = '{8'h0D, 1'b0, 12'h000, 8'h00, 6'd2, 6'd0,  6'd0};
    tbl[21] = '{8'h0A, 1'b0, 12'h000, 8'h00, 6'd3, 6'd0,  6'd0};
    tbl[22] = '{8'h0A, 1'b0, 12'h000, 8'h00, 6'd4, 6'd0,  6'd0};
    tbl[23] = '{8'h0A, 1'b0, 12'h000, 8'h00, 6'd5, 6'd0,  6'd0};
    tbl[24] = '{8'h08, 1'b1, 12'h13F, 8'h20, 6'd4, 6'd63, 6'd0};
    tbl[25] = '{8'h0A, 1'b0, 12'h000, 8'h00, 6'd5, 6'd63, 6'd0};
    tbl[26] = '{8'h5A, 1'b1, 12'h17F, 8'h5A, 6'd6, 6'd0,  6'd0};

    rst   = 1'b1;
    valid = 1'b0;
    ch    = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_cursor_top", {14'd0, crow, ccol, ctop}, 32'd0);
    rst = 1'b0;
    check_full_clear("init_clear");

    for (int i = 0; i < 27; i++) begin
      send(tbl[i].c);
      chk($sformatf("v%0d_we", i), 32'(we), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("v%0d_addr", i), 32'(addr), 32'(tbl[i].addr));
        chk($sformatf("v%0d_data", i), 32'(data), 32'(tbl[i].data));
      end
      chk($sformatf("v%0d_cursor", i), {14'd0, crow, ccol, ctop},
          {14'd0, tbl[i].row, tbl[i].col, tbl[i].top});
    end

    // Walk to (39,10) with top row 0.
    repeat (33) send(8'h0A);
    repeat (10) send(8'h61);
    chk("pre_scroll_cursor", {14'd0, crow, ccol, ctop}, {14'd0, 6'd39, 6'd10, 6'd0});

    // Scroll on LF at the bottom row.
    send(8'h0A);
    chk("scroll_cursor", {14'd0, crow, ccol, ctop}, {14'd0, 6'd39, 6'd10, 6'd1});
    chk("scroll_lf_no_write", 32'(we), 32'd0);
    lowcnt = 0;
    wcnt   = 0;
    errs   = 0;
    k      = 0;
    while (k < 200) begin
      if (!ready) lowcnt++;
      if (we) begin
        if (addr !== 12'(wcnt) || data !== 8'h20) errs++;
        wcnt++;
      end
      if (ready && !we) break;
      @(negedge clk);
      k++;
    end
    chk("scroll_ready_low_cycles", 32'(lowcnt), 32'd64);
    chk("scroll_writes", 32'(wcnt), 32'd64);
    chk("scroll_seq_errs", 32'(errs), 32'd0);

    // Bottom logical row now maps to physical row 0.
    send(8'h71);
    chk("wrap_phys_we", 32'(we), 32'd1);
    chk("wrap_phys_addr", 32'(addr), 32'h00A);
    chk("wrap_phys_data", 32'(data), 32'h71);
    chk("wrap_phys_cursor", {14'd0, crow, ccol, ctop}, {14'd0, 6'd39, 6'd11, 6'd1});

    // Second scroll clears physical row 1; reset after 20 blank writes.
    send(8'h0A);
    chk("scroll2_top", 32'(ctop), 32'd2);
    wcnt = 0;
    errs = 0;
    k    = 0;
    while (k < 200 && wcnt < 20) begin
      if (we) begin
        if (addr !== 12'h040 + 12'(wcnt)) errs++;
        wcnt++;
      end
      if (wcnt < 20) @(negedge clk);
      k++;
    end
    chk("scroll2_partial_writes", 32'(wcnt), 32'd20);
    chk("scroll2_seq_errs", 32'(errs), 32'd0);
    rst = 1'b1;
    #1;
    chk("midclear_rst_we_now", 32'(we), 32'd0);
    @(negedge clk);
    chk("midclear_rst_we", 32'(we), 32'd0);
    chk("midclear_rst_ready", 32'(ready), 32'd0);
    chk("midclear_rst_cursor_top", {14'd0, crow, ccol, ctop}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_full_clear("post_rst_clear");

    // Form feed after some text homes the cursor and clears everything.
    send(8'h41);
    chk("ff_pre_addr", 32'(addr), 32'h000);
    send(8'h0A);
    chk("ff_pre_cursor", {14'd0, crow, ccol, ctop}, {14'd0, 6'd1, 6'd1, 6'd0});
    send(8'h0C);
    chk("ff_cursor_top", {14'd0, crow, ccol, ctop}, 32'd0);
    chk("ff_ready_low", 32'(ready), 32'd0);
    check_full_clear("ff_clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
